// File: rtl/gate_sweep_ctrl.sv
// Sweeps p/q/r through all 8 vectors, waits SETTLE_CYCLES per vector, and captures the gate block's AND/OR truth tables.
// Optional self-check of the captured results is enabled with GATE_SWEEP_CHECK_EN.
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       p,
  output logic       q,
  output logic       r,
  input  logic       x_in,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] and_table,
  output logic [7:0] or_table,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic       last_vec;

  assign p = vec[2];
  assign q = vec[1];
  assign r = vec[0];

  assign last_vec = (vec == 3'd7);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        capture    = 1'b1;
        state_next = last_vec ? DONE : WAIT;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy and done are registered off the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 3'd0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      and_table <= 8'h00;
      or_table  <= 8'h00;
    end else begin
      state <= state_next;
      busy  <= (state_next == WAIT) || (state_next == SAMPLE);
      done  <= (state_next == DONE);
      if (accept) begin
        vec       <= 3'd0;
        cnt       <= 4'd0;
        and_table <= 8'h00;
        or_table  <= 8'h00;
      end
      if (state == WAIT) cnt <= cnt + 4'd1;
      if (capture) begin
        and_table[vec] <= x_in;
        or_table[vec]  <= y_in;
        if (!last_vec) begin
          vec <= vec + 3'd1;
          cnt <= 4'd0;
        end
      end
      if (state == DONE) vec <= 3'd0;
    end
  end

`ifdef GATE_SWEEP_CHECK_EN
  logic err_q;
  logic mismatch;

  // A correct gate block gives AND high only for 111 and OR low only for 000.
  assign mismatch = (x_in != last_vec) || (y_in != (vec != 3'd0));
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (capture && mismatch) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
